wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  Consumer end of the MEM/WB pipeline interface: writeback result select, architectural
//  register file (x0..x31) and retired-instruction counter. Takes the W-stage bundle
//  (regWriteW, resultSrcW, AluResultW, RDW, PCPlus4W, extImmW, RdW), writes ResultW to
//  RdW, and serves the two decode-stage read ports with same-cycle write->read bypass.
// PARAMETERS
//  DATA_W  32  register/data width
//  CNT_W   64  width of retired-instruction counter instretW
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst         in   1       synchronous reset, active-high
//  regWriteW   in   1       write enable from MEM/WB
//  resultSrcW  in   2       result select: 00 ALU, 01 mem RD, 10 PC+4, 11 extImm
//  AluResultW  in   DATA_W  ALU result
//  RDW         in   DATA_W  load data
//  PCPlus4W    in   DATA_W  link address
//  extImmW     in   DATA_W  extended immediate (LUI)
//  RdW         in   5       destination register index
//  validW      in   1       1 = real instruction retiring this cycle, 0 = bubble
//  Rs1D        in   5       decode read index A
//  Rs2D        in   5       decode read index B
//  RD1D        out  DATA_W  read data A
//  RD2D        out  DATA_W  read data B
//  ResultW     out  DATA_W  selected writeback value
//  instretW    out  CNT_W   retired-instruction count
// BEHAVIOUR
//  - ResultW: combinational 4:1 mux on resultSrcW; zero latency; independent of rst.
//  - Write: at posedge, if !rst && regWriteW && RdW!=0 then regs[RdW] <= ResultW.
//    RdW==0 writes are discarded; x0 has no storage and always reads 0.
//  - Read: combinational. RDnD = 0 if RsnD==0; else ResultW if regWriteW && RdW==RsnD
//    (bypass, same-cycle write visible to decode); else regs[RsnD]. Both ports may
//    bypass simultaneously when Rs1D==Rs2D==RdW.
//  - Bypass ignores validW; it is gated only by regWriteW, RdW!=0 and rst.
//  - rst high (sync): regs x1..x31 <= 0, instretW <= 0. rst wins over any same-cycle
//    write or increment. While rst high, RD1D/RD2D forced to 0 (no bypass).
//  - Reset values: RD1D=0, RD2D=0, instretW=0; ResultW follows inputs.
//  - instretW: +1 at posedge when validW && !rst; independent of regWriteW (stores and
//    branches retire). Wraps all-ones -> 0, no saturation or flag.
//  - No X propagation: unwritten registers read 0 after first reset.
// TESTING
//  1 rst=1 one cycle, then read Rs1D=5,Rs2D=31 -> RD1D=0, RD2D=0, instretW=0.
//  2 regWriteW=1,RdW=7,resultSrcW=00,AluResultW=0x1234_5678,validW=1; next cycle Rs1D=7
//    -> RD1D=0x1234_5678, instretW=1.
//  3 Same cycle regWriteW=1,RdW=9,resultSrcW=10,PCPlus4W=0x0000_0104, Rs1D=Rs2D=9
//    -> RD1D=RD2D=0x104 combinationally before edge; x9=0x104 after.
//  4 regWriteW=1,RdW=0,resultSrcW=11,extImmW=0xDEAD_B000; Rs1D=0 same and next cycle
//    -> RD1D=0 both cycles.
//  5 Write x3=0xAAAA_AAAA, then assert rst with regWriteW=1,RdW=3,RDW=0x5555_5555,
//    resultSrcW=01,validW=1 -> after edge x3=0, instretW=0; RD1D=0 during rst.
//  6 Force instretW to all-ones (CNT_W=4 build: 4'hF), validW=1 -> instretW=0; validW=0
//    with regWriteW=1 -> instretW unchanged, register still written.

Source files
------------

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback result select, x0..x31 register file with bypass, retired-instruction counter
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWriteW,
    input  logic [1:0]        resultSrcW,
    input  logic [DATA_W-1:0] AluResultW,
    input  logic [DATA_W-1:0] RDW,
    input  logic [DATA_W-1:0] PCPlus4W,
    input  logic [DATA_W-1:0] extImmW,
    input  logic [4:0]        RdW,
    input  logic              validW,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    output logic [DATA_W-1:0] RD1D,
    output logic [DATA_W-1:0] RD2D,
    output logic [DATA_W-1:0] ResultW,
    output logic [CNT_W-1:0]  instretW
);

    // x0 is hardwired to zero, so only x1..x31 have storage
    logic [DATA_W-1:0] regs [31:1];
    logic              wr_en;

    assign wr_en = regWriteW && (RdW != 5'd0);

    // writeback source select; purely combinational and not affected by rst
    always_comb begin
        ResultW = AluResultW;
        case (resultSrcW)
            2'b00:   ResultW = AluResultW;
            2'b01:   ResultW = RDW;
            2'b10:   ResultW = PCPlus4W;
            default: ResultW = extImmW;
        endcase
    end

    // register file update; reset clears every register and beats a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[RdW] <= ResultW;
        end
    end

    // retired-instruction counter; counts every valid retirement, wraps silently
    always_ff @(posedge clk) begin
        if (rst) begin
            instretW <= '0;
        end else if (validW) begin
            instretW <= instretW + 1'b1;
        end
    end

    // read port A: zero for x0 or during reset, bypass the in-flight write, else storage
    always_comb begin
        RD1D = '0;
        if (!rst && Rs1D != 5'd0) begin
            if (wr_en && RdW == Rs1D) begin
                RD1D = ResultW;
            end else begin
                RD1D = regs[Rs1D];
            end
        end
    end

    // read port B: same rules as port A
    always_comb begin
        RD2D = '0;
        if (!rst && Rs2D != 5'd0) begin
            if (wr_en && RdW == Rs2D) begin
                RD2D = ResultW;
            end else begin
                RD2D = regs[Rs2D];
            end
        end
    end

endmodule
